spi_receptor: RTL and testbench

SPI_RECEPTOR -- requirements
Module: spi_receptor

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_receptor.sv | 179 +++++++++++++++++
 tb/tb_spi_receptor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, default frame width, mode-to-edge mapping.
package spi_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Indexed by {CKP, CPH}: 1 means data is sampled on the falling SCK edge.
   // The leading edge is rising for CKP=0; CPH=1 moves sampling to the trailing edge.
   localparam logic [3:0] SAMPLE_FALL_MAP = 4'b0110;

   // The shift edge is always the opposite SCK edge to the sample edge.
   function automatic logic sample_on_fall(input logic ckp, input logic cph);
      return SAMPLE_FALL_MAP[{ckp, cph}];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third flop for rising/falling edge detection.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic meta;
   logic prev;

   // Synchronizer chain plus delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
         prev <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
         prev <= q;
      end
   end

   assign rise_c = q & ~prev;
   assign fall_c = ~q & prev;

endmodule

// File: rtl/spi_receptor.sv
// SPI slave receiver: all four CKP/CPH modes, MSB first, back-to-back frames.
module spi_receptor
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              CS,
   input  logic              SCK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] data_tx,
   output logic [DATA_W-1:0] data_rx,
   output logic              rx_valid,
   output logic              busy
);

   localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-2:0] rx_sr;
   logic [DATA_W-1:0] rx_word_c;
   logic              ckp_q, cph_q;
   logic              mosi_m, mosi_s;
   logic              sck_s, sck_rise_c, sck_fall_c, sck_edge_c;
   logic              cs_s, cs_rise_c, cs_fall_c;
   logic              sample_fall_c, sample_c, shift_c;
   logic [1:0]        settle;
   logic              armed;
   logic              start_c, load_c, sample_en_c, done_c, shift_en_c, clear_c;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
      .clk    (clk),
      .rst_n  (rst),
      .d      (SCK),
      .q      (sck_s),
      .rise_c (sck_rise_c),
      .fall_c (sck_fall_c)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .rst_n  (rst),
      .d      (CS),
      .q      (cs_s),
      .rise_c (cs_rise_c),
      .fall_c (cs_fall_c)
   );

   // MOSI synchronizer, same latency as the SCK path so data lines up with the edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mosi_m <= 1'b0;
         mosi_s <= 1'b0;
      end else begin
         mosi_m <= MOSI;
         mosi_s <= mosi_m;
      end
   end

   // Ignore the synthetic CS fall produced when reset releases with CS already low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         settle <= 2'd0;
         armed  <= 1'b0;
      end else begin
         if (settle != 2'd2) settle <= settle + 2'd1;
         if (settle == 2'd2 && cs_s) armed <= 1'b1;
      end
   end

   // Edge classification: after an edge, the new SCK level tells rise from fall
   assign sample_fall_c = sample_on_fall(ckp_q, cph_q);
   assign sck_edge_c    = sck_rise_c | sck_fall_c;
   assign sample_c      = sck_edge_c & (sck_s ^ sample_fall_c);
   assign shift_c       = sck_edge_c & ~(sck_s ^ sample_fall_c);
   assign rx_word_c     = {rx_sr, mosi_s};

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next state and datapath strobes
   always_comb begin
      state_nxt   = state;
      start_c     = 1'b0;
      load_c      = 1'b0;
      sample_en_c = 1'b0;
      done_c      = 1'b0;
      shift_en_c  = 1'b0;
      clear_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            clear_c = 1'b1;
            if (armed && cs_fall_c) begin
               start_c   = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_c    = 1'b1;
            state_nxt = cs_s ? ST_IDLE : ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cs_rise_c) begin
               clear_c   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               sample_en_c = sample_c;
               // CPH=0: the shift edge that closes a frame falls into the next one; skip it
               shift_en_c  = shift_c && (cph_q || cnt != '0);
               if (sample_c && cnt == CNT_LAST) begin
                  done_c    = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            load_c    = 1'b1;
            state_nxt = cs_s ? ST_IDLE : ST_SHIFT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ckp_q    <= 1'b0;
         cph_q    <= 1'b0;
         cnt      <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         data_rx  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         MISO     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         busy     <= (state_nxt == ST_SHIFT);
         if (start_c) begin
            ckp_q <= CKP;
            cph_q <= CPH;
         end
         if (load_c) begin
            cnt <= '0;
            if (cph_q) begin
               tx_sr <= data_tx;
            end else begin
               tx_sr <= data_tx << 1;
               MISO  <= data_tx[DATA_W-1];
            end
         end
         if (sample_en_c) begin
            rx_sr <= rx_word_c[DATA_W-2:0];
            cnt   <= cnt + CNT_W'(1);
         end
         if (done_c) begin
            data_rx  <= rx_word_c;
            rx_valid <= 1'b1;
         end
         if (shift_en_c) begin
            MISO  <= tx_sr[DATA_W-1];
            tx_sr <= tx_sr << 1;
         end
         if (clear_c) cnt <= '0;
         if (state_nxt == ST_IDLE) MISO <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_receptor.sv
// Randomized SPI-master bench with a scoreboard for received words.
`timescale 1ns/1ps
module tb_spi_receptor;

   logic       clk;
   logic       rst;
   logic       CKP, CPH, CS, SCK, MOSI;
   logic       MISO;
   logic [7:0] data_tx;
   logic [7:0] data_rx;
   logic       rx_valid;
   logic       busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         last_sample_cyc = 0;
   int         n_pulses = 0;
   int         n_expected = 0;
   logic [7:0] last_rx = 8'h00;
   logic [7:0] sb_q[$];

   spi_receptor #(.DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .CKP      (CKP),
      .CPH      (CPH),
      .CS       (CS),
      .SCK      (SCK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .data_tx  (data_tx),
      .data_rx  (data_rx),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every rx_valid pulse must match the oldest completed frame
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (rx_valid === 1'b1) begin
            n_pulses++;
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rx_valid_unexpected: got pulse with data_rx 0x%0h, expected none", data_rx);
            end else begin
               logic [7:0] exp;
               exp = sb_q.pop_front();
               check("data_rx", 32'(data_rx), 32'(exp));
               check("rx_latency_le4", 32'((cyc - last_sample_cyc) <= 4), 32'(1));
               last_rx = exp;
            end
         end else begin
            check("data_rx_hold", 32'(data_rx), 32'(last_rx));
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame(input logic ckp, input logic cph);
      CKP = ckp;
      CPH = cph;
      SCK = ckp;
      wait_clk(6);
      CS = 1'b0;
      wait_clk(8);
   endtask

   task automatic end_frame(input int half);
      wait_clk(half);
      CS = 1'b1;
      wait_clk(6);
      check("busy_idle", 32'(busy), 32'(0));
      check("miso_idle", 32'(MISO), 32'(0));
   endtask

   // Master side of nbits bits; returns the MISO word seen at the sample edges
   task automatic run_bits(input logic [7:0] mo, input int nbits, input int half,
                           input logic ckp, input logic cph, input logic [7:0] next_tx,
                           output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (i == 2) begin
            CKP = 1'($urandom);
            CPH = 1'($urandom);
         end
         if (i == 3) check("busy_mid", 32'(busy), 32'(1));
         if (i == 4) data_tx = next_tx;
         if (!cph) begin
            MOSI = mo[7-i];
            wait_clk(half);
            got = {got[6:0], MISO};
            if (i == 7) begin
               sb_q.push_back(mo);
               n_expected++;
               last_sample_cyc = cyc;
            end
            SCK = ~SCK;
            wait_clk(half);
            SCK = ~SCK;
         end else begin
            wait_clk(half);
            SCK = ~SCK;
            MOSI = mo[7-i];
            wait_clk(half);
            got = {got[6:0], MISO};
            if (i == 7) begin
               sb_q.push_back(mo);
               n_expected++;
               last_sample_cyc = cyc;
            end
            SCK = ~SCK;
         end
      end
      if (ckp == 1'b0 && SCK !== 1'b0) check("sck_idle", 32'(SCK), 32'(0));
   endtask

   task automatic single_frame(input logic [7:0] mo, input logic [7:0] tx,
                               input logic ckp, input logic cph, input int half, input string name);
      logic [7:0] got;
      data_tx = tx;
      start_frame(ckp, cph);
      run_bits(mo, 8, half, ckp, cph, tx, got);
      check(name, 32'(got), 32'(tx));
      end_frame(half);
   endtask

   initial begin
      #300us;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] got;
      logic [7:0] cur_tx, nxt_tx, mo;
      logic       ckp, cph;
      int         half, nfr;

      rst = 1'b0; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
      CKP = 1'b0; CPH = 1'b0; data_tx = 8'h00;
      wait_clk(3);
      check("rst_data_rx", 32'(data_rx), 32'(0));
      check("rst_rx_valid", 32'(rx_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_miso", 32'(MISO), 32'(0));
      rst = 1'b1;
      wait_clk(6);

      // Mode 0 reference frame
      single_frame(8'h55, 8'hA3, 1'b0, 1'b0, 4, "miso_mode0_A3");

      // All four modes
      for (int m = 0; m < 4; m++) begin
         single_frame(8'hC9, 8'($urandom), 1'(m >> 1), 1'(m), 4, "miso_all_modes");
      end

      // Back-to-back frames with CS held low
      data_tx = 8'h5A;
      start_frame(1'b0, 1'b0);
      run_bits(8'h12, 8, 4, 1'b0, 1'b0, 8'hE7, got);
      check("miso_b2b_first", 32'(got), 32'(8'h5A));
      run_bits(8'h34, 8, 4, 1'b0, 1'b0, 8'hE7, got);
      check("miso_b2b_second", 32'(got), 32'(8'hE7));
      end_frame(4);

      // Abort after 5 bits
      data_tx = 8'h66;
      start_frame(1'b0, 1'b1);
      run_bits(8'hFF, 5, 4, 1'b0, 1'b1, 8'h66, got);
      wait_clk(4);
      CS = 1'b1;
      wait_clk(3);
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_data_rx", 32'(data_rx), 32'(last_rx));
      wait_clk(6);
      check("abort_miso", 32'(MISO), 32'(0));

      // Reset in the middle of a frame, released with CS still low
      data_tx = 8'h99;
      start_frame(1'b1, 1'b0);
      run_bits(8'hA5, 4, 4, 1'b1, 1'b0, 8'h99, got);
      rst = 1'b0;
      last_rx = 8'h00;
      #1;
      check("midrst_data_rx", 32'(data_rx), 32'(0));
      check("midrst_rx_valid", 32'(rx_valid), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_miso", 32'(MISO), 32'(0));
      wait_clk(3);
      rst = 1'b1;
      wait_clk(10);
      check("midrst_no_spurious_start", 32'(busy), 32'(0));
      CS = 1'b1;
      wait_clk(6);
      single_frame(8'h81, 8'h3E, 1'b1, 1'b0, 4, "miso_after_reset");

      // Minimum SCK half-period
      single_frame(8'h3C, 8'hC5, 1'b1, 1'b1, 4, "miso_min_half");

      // Randomized modes, speeds and frame bursts
      for (int k = 0; k < 16; k++) begin
         ckp    = 1'($urandom);
         cph    = 1'($urandom);
         half   = int'($urandom_range(7, 4));
         nfr    = int'($urandom_range(3, 1));
         cur_tx = 8'($urandom);
         data_tx = cur_tx;
         start_frame(ckp, cph);
         for (int f = 0; f < nfr; f++) begin
            mo     = 8'($urandom);
            nxt_tx = 8'($urandom);
            run_bits(mo, 8, half, ckp, cph, nxt_tx, got);
            check("miso_random", 32'(got), 32'(cur_tx));
            cur_tx = nxt_tx;
         end
         end_frame(half);
      end

      wait_clk(10);
      check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
      check("rx_valid_count", 32'(n_pulses), 32'(n_expected));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
